// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes and an iterative shift-add multiplier.
// Define ALU_FLAGS_EN to add registered carry/overflow outputs for ADD/SUB.
module alu_seq #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] data_rs1,
   input  logic [DATA_WIDTH-1:0] source_2,
   input  logic [2:0]            alu_inst,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALU_result,
   output logic                  zero,
   output logic                  busy
`ifdef ALU_FLAGS_EN
   ,
   output logic                  carry,
   output logic                  overflow
`endif
);

   localparam int SHAMT_W = $clog2(DATA_WIDTH);
   localparam int MSB     = DATA_WIDTH - 1;
   localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(DATA_WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic                  r_busy;
   logic                  r_zero;
   logic [DATA_WIDTH-1:0] r_result;
   logic [SHAMT_W-1:0]    r_cnt;
   logic [DATA_WIDTH-1:0] r_mcand;
   logic [DATA_WIDTH-1:0] r_mplier;
   logic [DATA_WIDTH-1:0] r_acc;

   logic [DATA_WIDTH-1:0] w_add;
   logic [DATA_WIDTH-1:0] w_sub;
   logic [DATA_WIDTH-1:0] w_result;
   logic [DATA_WIDTH-1:0] w_acc_next;
   logic [SHAMT_W-1:0]    w_shamt;
   logic                  w_shift_oob;

   assign w_shamt     = source_2[SHAMT_W-1:0];
   assign w_shift_oob = (32'(w_shamt) >= DATA_WIDTH);
   assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef ALU_FLAGS_EN
   logic w_add_c;
   logic w_sub_b;
   logic w_carry;
   logic w_ovf;
   logic r_carry;
   logic r_ovf;

   assign {w_add_c, w_add} = {1'b0, data_rs1} + {1'b0, source_2};
   // The extra bit of the widened difference is set exactly when rs1 < src2 (borrow).
   assign {w_sub_b, w_sub} = {1'b0, data_rs1} - {1'b0, source_2};

   always_comb begin
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      case (alu_inst)
         OP_ADD: begin
            w_carry = w_add_c;
            w_ovf   = (data_rs1[MSB] == source_2[MSB]) && (w_add[MSB] != data_rs1[MSB]);
         end
         OP_SUB: begin
            w_carry = w_sub_b;
            w_ovf   = (data_rs1[MSB] != source_2[MSB]) && (w_sub[MSB] != data_rs1[MSB]);
         end
         default: ;
      endcase
   end

   assign carry    = r_carry;
   assign overflow = r_ovf;
`else
   assign w_add = data_rs1 + source_2;
   assign w_sub = data_rs1 - source_2;
`endif

   always_comb begin
      w_result = '0;
      case (alu_inst)
         OP_ADD: w_result = w_add;
         OP_SUB: w_result = w_sub;
         OP_AND: w_result = data_rs1 & source_2;
         OP_OR:  w_result = data_rs1 | source_2;
         OP_XOR: w_result = data_rs1 ^ source_2;
         OP_SLL: w_result = w_shift_oob ? '0 : (data_rs1 << w_shamt);
         OP_SRL: w_result = w_shift_oob ? '0 : (data_rs1 >> w_shamt);
         default: w_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_zero      <= 1'b0;
         r_result    <= '0;
         r_cnt       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
`ifdef ALU_FLAGS_EN
         r_carry     <= 1'b0;
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_in_ready <= 1'b0;
                  if (alu_inst == OP_MUL) begin
                     r_state  <= S_EXEC;
                     r_busy   <= 1'b1;
                     r_cnt    <= '0;
                     r_mcand  <= data_rs1;
                     r_mplier <= source_2;
                     r_acc    <= '0;
                  end else begin
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                     r_result    <= w_result;
                     r_zero      <= (w_result == '0);
`ifdef ALU_FLAGS_EN
                     r_carry     <= w_carry;
                     r_ovf       <= w_ovf;
`endif
                  end
               end
            end
            S_EXEC: begin
               // One partial product per cycle: multiplicand walks left, multiplier right.
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + SHAMT_W'(1);
               if (r_cnt == LAST_ITER) begin
                  r_state     <= S_DONE;
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_result    <= w_acc_next;
                  r_zero      <= (w_acc_next == '0);
`ifdef ALU_FLAGS_EN
                  r_carry     <= 1'b0;
                  r_ovf       <= 1'b0;
`endif
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign busy       = r_busy;
   assign zero       = r_zero;
   assign ALU_result = r_result;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: one 5-bit and one 8-bit instance sharing clock and reset.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_zero, a_busy;
   logic [4:0] a_rs1, a_src2, a_result;
   logic [2:0] a_inst;

   logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_zero, b_busy;
   logic [7:0] b_rs1, b_src2, b_result;
   logic [2:0] b_inst;

`ifdef ALU_FLAGS_EN
   logic a_carry, a_overflow, b_carry, b_overflow;
`endif

   alu_seq #(.DATA_WIDTH(5)) u_dut5 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (a_in_valid),
      .in_ready   (a_in_ready),
      .data_rs1   (a_rs1),
      .source_2   (a_src2),
      .alu_inst   (a_inst),
      .out_valid  (a_out_valid),
      .out_ready  (a_out_ready),
      .ALU_result (a_result),
      .zero       (a_zero),
      .busy       (a_busy)
`ifdef ALU_FLAGS_EN
      ,
      .carry      (a_carry),
      .overflow   (a_overflow)
`endif
   );

   alu_seq #(.DATA_WIDTH(8)) u_dut8 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (b_in_valid),
      .in_ready   (b_in_ready),
      .data_rs1   (b_rs1),
      .source_2   (b_src2),
      .alu_inst   (b_inst),
      .out_valid  (b_out_valid),
      .out_ready  (b_out_ready),
      .ALU_result (b_result),
      .zero       (b_zero),
      .busy       (b_busy)
`ifdef ALU_FLAGS_EN
      ,
      .carry      (b_carry),
      .overflow   (b_overflow)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Single non-MUL operation on the 5-bit instance, result one cycle after accept.
   task automatic op5(input string tag, input logic [2:0] op, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] exp);
      @(negedge clk);
      check_eq({tag, ".in_ready"}, 32'(a_in_ready), 32'd1);
      a_inst = op; a_rs1 = a; a_src2 = b; a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0; a_rs1 = ~a; a_src2 = ~b; a_inst = ~op;
      check_eq({tag, ".out_valid"}, 32'(a_out_valid), 32'd1);
      check_eq({tag, ".result"}, 32'(a_result), 32'(exp));
      check_eq({tag, ".zero"}, 32'(a_zero), 32'(exp == 5'd0));
      $display("W5 %s: a=%0d b=%0d result=%0d zero=%0b", tag, a, b, a_result, a_zero);
      a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;
      check_eq({tag, ".drop"}, 32'(a_out_valid), 32'd0);
   endtask

   // Single operation on the 8-bit instance; MUL also checks busy and latency.
   task automatic op8(input string tag, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp,
                      input logic exp_c, input logic exp_v);
      @(negedge clk);
      check_eq({tag, ".in_ready"}, 32'(b_in_ready), 32'd1);
      b_inst = op; b_rs1 = a; b_src2 = b; b_in_valid = 1'b1;
      if (op == 3'b111) begin
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b_in_valid = 1'b0; b_rs1 = 8'h5A; b_src2 = 8'hC3; b_inst = 3'b000;
            check_eq({tag, ".busy"}, 32'(b_busy), 32'd1);
            check_eq({tag, ".early"}, 32'(b_out_valid), 32'd0);
         end
      end
      @(negedge clk);
      b_in_valid = 1'b0; b_rs1 = ~a; b_src2 = ~b; b_inst = ~op;
      check_eq({tag, ".out_valid"}, 32'(b_out_valid), 32'd1);
      check_eq({tag, ".busy_off"}, 32'(b_busy), 32'd0);
      check_eq({tag, ".result"}, 32'(b_result), 32'(exp));
      check_eq({tag, ".zero"}, 32'(b_zero), 32'(exp == 8'd0));
`ifdef ALU_FLAGS_EN
      check_eq({tag, ".carry"}, 32'(b_carry), 32'(exp_c));
      check_eq({tag, ".overflow"}, 32'(b_overflow), 32'(exp_v));
`else
      if (exp_c || exp_v) begin end
`endif
      $display("W8 %s: a=0x%0h b=0x%0h result=0x%0h zero=%0b", tag, a, b, b_result, b_zero);
      b_out_ready = 1'b1;
      @(negedge clk);
      b_out_ready = 1'b0;
      check_eq({tag, ".drop"}, 32'(b_out_valid), 32'd0);
   endtask

   initial begin
      bit seen_valid;
      rst = 1'b1;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_rs1 = '0; a_src2 = '0; a_inst = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_rs1 = '0; b_src2 = '0; b_inst = '0;
      repeat (2) @(negedge clk);
      check_eq("rst.in_ready", 32'(a_in_ready), 32'd1);
      check_eq("rst.out_valid", 32'(a_out_valid), 32'd0);
      check_eq("rst.result", 32'(a_result), 32'd0);
      check_eq("rst.zero", 32'(a_zero), 32'd0);
      check_eq("rst.busy", 32'(b_busy), 32'd0);
      rst = 1'b0;

      op5("add5",  3'b000, 5'd5,  5'd5,  5'd10);
      op5("sub5",  3'b001, 5'd5,  5'd5,  5'd0);
      op5("and5",  3'b010, 5'd12, 5'd10, 5'd8);
      op5("or5",   3'b011, 5'd12, 5'd10, 5'd14);
      op5("xor5",  3'b100, 5'd12, 5'd10, 5'd6);
      op5("subw5", 3'b001, 5'd3,  5'd5,  5'd30);
      op5("srl6",  3'b110, 5'b10110, 5'd6, 5'd0);
      op5("srl2",  3'b110, 5'b10110, 5'd2, 5'b00101);
      op5("sll2",  3'b101, 5'b00011, 5'd2, 5'b01100);
      op5("sll5",  3'b101, 5'b00011, 5'd5, 5'd0);

      op8("mul13x11", 3'b111, 8'd13,  8'd11,  8'd143, 1'b0, 1'b0);
      op8("mul20x20", 3'b111, 8'd20,  8'd20,  8'd144, 1'b0, 1'b0);
      op8("mulff",    3'b111, 8'hFF,  8'hFF,  8'h01,  1'b0, 1'b0);
      op8("addcarry", 3'b000, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b0);
      op8("addovf",   3'b000, 8'h7F,  8'h01,  8'h80,  1'b0, 1'b1);
      op8("subbrw",   3'b001, 8'h03,  8'h05,  8'hFE,  1'b1, 1'b0);
      op8("subovf",   3'b001, 8'h80,  8'h01,  8'h7F,  1'b0, 1'b1);
      op8("xor8",     3'b100, 8'hF0,  8'hFF,  8'h0F,  1'b0, 1'b0);
      op8("srl8",     3'b110, 8'h80,  8'd7,   8'h01,  1'b0, 1'b0);

      // Backpressure: result held while out_ready=0, competing input ignored.
      @(negedge clk);
      a_inst = 3'b000; a_rs1 = 5'd7; a_src2 = 5'd9; a_in_valid = 1'b1;
      @(negedge clk);
      a_inst = 3'b011; a_rs1 = 5'd1; a_src2 = 5'd2;
      for (int i = 0; i < 3; i++) begin
         check_eq("bp.valid", 32'(a_out_valid), 32'd1);
         check_eq("bp.result", 32'(a_result), 32'd16);
         check_eq("bp.zero", 32'(a_zero), 32'd0);
         check_eq("bp.in_ready", 32'(a_in_ready), 32'd0);
         @(negedge clk);
      end
      $display("W5 bp: held result=%0d for 3 cycles", a_result);
      a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;
      check_eq("bp.idle_valid", 32'(a_out_valid), 32'd0);
      check_eq("bp.idle_ready", 32'(a_in_ready), 32'd1);
      @(negedge clk);
      a_in_valid = 1'b0;
      check_eq("bp.new_valid", 32'(a_out_valid), 32'd1);
      check_eq("bp.new_result", 32'(a_result), 32'd3);
      $display("W5 bp: follow-up OR result=%0d", a_result);
      a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;

      // Reset in the middle of a multiply: no result may ever appear.
      @(negedge clk);
      b_inst = 3'b111; b_rs1 = 8'd13; b_src2 = 8'd11; b_in_valid = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("rmul.busy", 32'(b_busy), 32'd0);
      check_eq("rmul.in_ready", 32'(b_in_ready), 32'd1);
      check_eq("rmul.out_valid", 32'(b_out_valid), 32'd0);
      check_eq("rmul.result", 32'(b_result), 32'd0);
      seen_valid = 1'b0;
      b_out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (b_out_valid) seen_valid = 1'b1;
      end
      b_out_ready = 1'b0;
      check_eq("rmul.never_valid", 32'(seen_valid), 32'd0);
      $display("W8 rmul: aborted multiply, out_valid seen=%0b", seen_valid);
      op8("mulpost", 3'b111, 8'd6, 8'd7, 8'd42, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
